goldschmidt_div_seq: RTL and testbench

- Self-sequenced, parametrised Goldschmidt fixed-point divider. It replaces the separate datapath-plus-external-counter arrangement with one block that has an integrated FSM.
- Provides a start/busy/done handshake, a configurable iteration count, a remainder step and a non-normalised-divisor error flag.
- Sits between operand staging and result writeback in the divide unit. Uses one shared WIDTH x WIDTH multiplier, time-multiplexed.

---
 rtl/goldschmidt_div_seq.sv | 180 ++++++++++++++++++
 tb/tb_goldschmidt_div_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_div_seq.sv
// Self-sequenced Goldschmidt fixed-point divider, Q2.(WIDTH-2) operands.
// One shared WIDTH x WIDTH multiplier is time-multiplexed across the
// numerator, denominator and remainder steps under a small FSM.
module goldschmidt_div_seq #(
   parameter int              WIDTH = 30,
   parameter int              ITERS = 4,
   parameter logic [WIDTH-1:0] K0   = {3'b011, {(WIDTH-3){1'b0}}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] numerator,
   input  logic [WIDTH-1:0] denominator,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      NUM  = 3'd1,
      DEN  = 3'd2,
      REM  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [WIDTH-1:0]  n;
   logic [WIDTH-1:0]  d;
   logic [WIDTH-1:0]  k;
   logic [WIDTH-1:0]  r;
   logic [WIDTH-1:0]  n_lat;
   logic [WIDTH-1:0]  d_lat;
   logic [CW-1:0]     cnt;
   logic              bad_div;
   logic              norm;
   logic              last_iter;
   logic [WIDTH-1:0]  mul_a;
   logic [WIDTH-1:0]  mul_b;
   logic [2*WIDTH-1:0] prod_full;
   logic [WIDTH-1:0]  prod;
   logic              unused_prod_bits;

   // Divisor must lie in [0.5,1): integer bits clear, top fraction bit set.
   function automatic logic is_normalised(input logic [WIDTH-1:0] v);
      return (v[WIDTH-1:WIDTH-2] == 2'b00) && v[WIDTH-3];
   endfunction

   assign norm      = is_normalised(denominator);
   assign last_iter = (cnt == CW'(ITERS - 1));

   // Select the operand pair for the single shared multiplier.
   always_comb begin
      mul_a = n;
      mul_b = k;
      case (state)
         NUM:     begin mul_a = n; mul_b = k;     end
         DEN:     begin mul_a = d; mul_b = k;     end
         REM:     begin mul_a = n; mul_b = d_lat; end
         default: begin mul_a = n; mul_b = k;     end
      endcase
   end

   // Full product, rescaled back to Q2.(WIDTH-2) by truncation.
   assign prod_full        = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
   assign prod             = prod_full[2*WIDTH-3:WIDTH-2];
   assign unused_prod_bits = ^{prod_full[2*WIDTH-1:2*WIDTH-2], prod_full[WIDTH-3:0]};

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (norm) begin
                  next_state = NUM;
               end else begin
                  next_state = DONE;
               end
            end else begin
               next_state = IDLE;
            end
         end
         NUM: next_state = DEN;
         DEN: begin
            if (last_iter) begin
               next_state = REM;
            end else begin
               next_state = NUM;
            end
         end
         REM:     next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Iteration datapath: operand latch, n/d/k refinement, remainder product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n       <= {WIDTH{1'b0}};
         d       <= {WIDTH{1'b0}};
         k       <= {WIDTH{1'b0}};
         r       <= {WIDTH{1'b0}};
         n_lat   <= {WIDTH{1'b0}};
         d_lat   <= {WIDTH{1'b0}};
         cnt     <= {CW{1'b0}};
         bad_div <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (norm) begin
                     n       <= numerator;
                     d       <= denominator;
                     k       <= K0;
                     n_lat   <= numerator;
                     d_lat   <= denominator;
                     cnt     <= {CW{1'b0}};
                     bad_div <= 1'b0;
                  end else begin
                     bad_div <= 1'b1;
                  end
               end
            end
            NUM: n <= prod;
            DEN: begin
               d <= prod;
               // One's complement of the fraction field approximates 2 - d.
               k <= {1'b0, ~prod[WIDTH-2:0]};
               if (!last_iter) begin
                  cnt <= cnt + CW'(1);
               end
            end
            REM:     r <= prod;
            default: ;
         endcase
      end
   end

   // Registered handshake and results; results change only when leaving DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         quotient  <= {WIDTH{1'b0}};
         remainder <= {WIDTH{1'b0}};
      end else begin
         busy <= (next_state != IDLE);
         done <= (state == DONE);
         if (state == DONE) begin
            if (bad_div) begin
               err       <= 1'b1;
               quotient  <= {WIDTH{1'b1}};
               remainder <= {WIDTH{1'b0}};
            end else begin
               err       <= 1'b0;
               quotient  <= n;
               remainder <= n_lat - r;
            end
         end
      end
   end

endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Bench for goldschmidt_div_seq: three instances (ITERS = 4, 1, 6) at WIDTH=16,
// directed and random divides checked against an arithmetic reference model.
module tb_goldschmidt_div_seq;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  numerator;
   logic [W-1:0]  denominator;
   logic          st   [3];
   logic          busy [3];
   logic          done [3];
   logic          err  [3];
   logic [W-1:0]  quot [3];
   logic [W-1:0]  rem  [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   goldschmidt_div_seq #(.WIDTH(W), .ITERS(4)) u4 (
      .clk(clk), .reset(reset), .start(st[0]), .numerator(numerator),
      .denominator(denominator), .busy(busy[0]), .done(done[0]), .err(err[0]),
      .quotient(quot[0]), .remainder(rem[0]));
   goldschmidt_div_seq #(.WIDTH(W), .ITERS(1)) u1 (
      .clk(clk), .reset(reset), .start(st[1]), .numerator(numerator),
      .denominator(denominator), .busy(busy[1]), .done(done[1]), .err(err[1]),
      .quotient(quot[1]), .remainder(rem[1]));
   goldschmidt_div_seq #(.WIDTH(W), .ITERS(6)) u6 (
      .clk(clk), .reset(reset), .start(st[2]), .numerator(numerator),
      .denominator(denominator), .busy(busy[2]), .done(done[2]), .err(err[2]),
      .quotient(quot[2]), .remainder(rem[2]));

   function automatic int iters_of(input int u);
      return (u == 0) ? 4 : ((u == 1) ? 1 : 6);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_le(input string tag, input int obs, input int limit);
      total++;
      assert (obs <= limit) else begin
         bad++;
         $error("FAIL %s observed=%0d expected<=%0d", tag, obs, limit);
      end
   endtask

   // Reference: values are reals scaled by 2^14; products truncate back to
   // that scale and wrap modulo 2^16; k starts at 1.5 and becomes (2 - d) - 1 LSB.
   task automatic model(input int it, input logic [15:0] nn, input logic [15:0] dd,
                        output logic [15:0] q, output logic [15:0] r, output logic e);
      longint n, d, k, t;
      if (!(dd >= 16'h2000 && dd < 16'h4000)) begin
         q = 16'hFFFF;
         r = 16'h0000;
         e = 1'b1;
      end else begin
         n = longint'(nn);
         d = longint'(dd);
         k = 64'sd24576;
         for (int i = 0; i < it; i++) begin
            n = ((n * k) / 64'sd16384) % 64'sd65536;
            d = ((d * k) / 64'sd16384) % 64'sd65536;
            k = 64'sd32767 - (d % 64'sd32768);
         end
         q = n[15:0];
         t = longint'(nn) - (((n * longint'(dd)) / 64'sd16384) % 64'sd65536);
         r = t[15:0];
         e = 1'b0;
      end
   endtask

   task automatic run(input int u, input logic [15:0] nn, input logic [15:0] dd,
                      output logic [15:0] q, output logic [15:0] r, output logic e,
                      output int lat);
      logic [15:0] prev_q;
      prev_q = quot[u];
      @(negedge clk);
      numerator   = nn;
      denominator = dd;
      st[u]       = 1'b1;
      @(posedge clk);
      #1;
      st[u]       = 1'b0;
      numerator   = 16'($urandom);
      denominator = 16'($urandom);
      check("busy_after_accept", busy[u], 1'b1);
      check("quot_held_on_accept", quot[u], prev_q);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done[u]) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) check("done_timeout", 1'b0, 1'b1);
      q = quot[u];
      r = rem[u];
      e = err[u];
      @(posedge clk);
      #1;
      check("done_one_cycle", done[u], 1'b0);
   endtask

   task automatic div_check(input int u, input logic [15:0] nn, input logic [15:0] dd,
                            output logic [15:0] q);
      logic [15:0] r, eq, er;
      logic        e, ee;
      int          lat;
      run(u, nn, dd, q, r, e, lat);
      model(iters_of(u), nn, dd, eq, er, ee);
      check("latency", lat, ee ? 1 : 2 * iters_of(u) + 2);
      check("quotient", q, eq);
      check("remainder", r, er);
      check("err", e, ee);
   endtask

   function automatic int abs_err(input logic [15:0] q, input logic [15:0] nn, input logic [15:0] dd);
      int exact;
      exact = int'((longint'(nn) * 64'sd16384) / longint'(dd));
      return (int'(q) > exact) ? int'(q) - exact : exact - int'(q);
   endfunction

   initial begin
      logic [15:0] q, q1, q4, q6, nn, dd, eq, er, held_q, held_r;
      logic        ee;
      int          pulses [$];
      int          npulse;

      reset       = 1'b1;
      st[0]       = 1'b0;
      st[1]       = 1'b0;
      st[2]       = 1'b0;
      numerator   = 16'h0000;
      denominator = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy[0], 1'b0);
      check("reset_done", done[0], 1'b0);
      check("reset_err", err[0], 1'b0);
      check("reset_quot", quot[0], 16'h0000);
      check("reset_rem", rem[0], 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      // 0.75 / 0.5
      div_check(0, 16'h3000, 16'h2000, q);
      total++;
      assert (q >= 16'h5FF8 && q <= 16'h6000) else begin
         bad++;
         $error("FAIL q_range_0p75_0p5 observed=%0h expected=5ff8..6000", q);
      end
      held_q = quot[0];
      held_r = rem[0];
      repeat (4) @(posedge clk);
      #1;
      check("hold_quot", quot[0], held_q);
      check("hold_rem", rem[0], held_r);

      // 1.0 / (1 - lsb)
      div_check(0, 16'h4000, 16'h3FFF, q);

      // Non-normalised divisors, then a valid divide clears err.
      div_check(0, 16'h3000, 16'h1000, q);
      div_check(0, 16'h3000, 16'h0000, q);
      div_check(0, 16'h2800, 16'h3000, q);

      // Start held high: one acceptance per IDLE, pulses spaced 2*ITERS+3.
      model(4, 16'h1234, 16'h2ABC, eq, er, ee);
      @(negedge clk);
      numerator   = 16'h1234;
      denominator = 16'h2ABC;
      st[0]       = 1'b1;
      for (int i = 0; i <= 34; i++) begin
         @(posedge clk);
         #1;
         if (done[0]) begin
            pulses.push_back(i);
            check("held_quot", quot[0], eq);
            check("held_busy_in_done_cycle", busy[0], 1'b0);
         end
         if (i == 22) st[0] = 1'b0;
      end
      npulse = pulses.size();
      check("held_pulse_count", npulse, 3);
      if (npulse == 3) begin
         check("held_first_pulse", pulses[0], 10);
         check("held_spacing_1", pulses[1] - pulses[0], 11);
         check("held_spacing_2", pulses[2] - pulses[1], 11);
      end

      // Reset during DEN of the second iteration.
      @(negedge clk);
      numerator   = 16'h3800;
      denominator = 16'h3100;
      st[0]       = 1'b1;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_busy", busy[0], 1'b0);
      check("midreset_done", done[0], 1'b0);
      check("midreset_err", err[0], 1'b0);
      check("midreset_quot", quot[0], 16'h0000);
      check("midreset_rem", rem[0], 16'h0000);
      @(negedge clk);
      reset  = 1'b0;
      npulse = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done[0]) npulse++;
      end
      check("midreset_no_done", npulse, 0);
      div_check(0, 16'h3800, 16'h3100, q);

      // Random normalised divides on all three iteration counts.
      for (int t = 0; t < 8; t++) begin
         dd = 16'($urandom_range(16'h2000, 16'h3FFF));
         nn = 16'($urandom_range(0, 2 * int'(dd) - 1));
         div_check(1, nn, dd, q1);
         div_check(0, nn, dd, q4);
         div_check(2, nn, dd, q6);
         check_le("iters6_accuracy", abs_err(q6, nn, dd), 24);
         check_le("iters4_vs_1", abs_err(q4, nn, dd), abs_err(q1, nn, dd) + 16);
         check_le("iters6_vs_4", abs_err(q6, nn, dd), abs_err(q4, nn, dd) + 16);
      end

      // Random non-normalised divisors.
      for (int t = 0; t < 3; t++) begin
         dd = 16'($urandom_range(16'h4000, 16'hFFFF));
         nn = 16'($urandom);
         div_check(0, nn, dd, q);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
